// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

   localparam int SUB_WIDTH_DEF = 4;

   // RUN and FINISH each own one bit, so Busy and Done come straight off flops.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FINISH = 2'b10
   } state_t;

   // Signed overflow of a - b: the operand signs differ and the result sign differs from a.
   function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, with Start/Busy/Done handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for Start; results hold
// RUN    | one bit per edge while En=1; all state holds while En=0
// FINISH | Done pulse; Start here re-arms immediately without an IDLE gap
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow,
   output logic             Overflow,
   output logic             Busy,
   output logic             Done
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res;
   logic               br;
   logic               a_msb;
   logic               b_msb;
   logic [WIDTH-1:0]   diff_q;
   logic               borrow_q;
   logic               ovf_q;

   logic               d_bit;
   logic               bout_bit;
   logic [WIDTH-1:0]   res_next;
   logic               last_bit;

   // The single bit cell is reused every cycle on the current LSBs and borrow.
   full_subtractor_bit u_fsb (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign res_next = {d_bit, res[WIDTH-1:1]};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // Sequencer, datapath shift registers and result registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         a_sr     <= '0;
         b_sr     <= '0;
         res      <= '0;
         br       <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               if (Start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  a_msb <= A[WIDTH-1];
                  b_msb <= B[WIDTH-1];
                  res   <= '0;
                  br    <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (En) begin
                  res  <= res_next;
                  a_sr <= a_sr >> 1;
                  b_sr <= b_sr >> 1;
                  br   <= bout_bit;
                  cnt  <= cnt + CNT_W'(1);
                  if (last_bit) begin
                     diff_q   <= res_next;
                     borrow_q <= bout_bit;
                     ovf_q    <= sub_overflow(a_msb, b_msb, d_bit);
                     state    <= FINISH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Diff     = diff_q;
   assign Borrow   = borrow_q;
   assign Overflow = ovf_q;
   assign Busy     = state[0];
   assign Done     = state[1];

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk_sys = 1'b0;
   logic         rst_n;
   logic         en;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;
   logic         busy;
   logic         done;

   int vectors = 0;
   int miscompares = 0;

   logic [W-1:0] held_diff = '0;
   logic         held_borrow = 1'b0;
   logic         held_ovf = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .Clk      (clk_sys),
      .Rst_n    (rst_n),
      .En       (en),
      .Start    (start),
      .A        (a_in),
      .B        (b_in),
      .Diff     (diff),
      .Borrow   (borrow),
      .Overflow (overflow),
      .Busy     (busy),
      .Done     (done)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic bo, output logic ov);
      int ua, ub, sa, sb, r;
      ua = int'(a);
      ub = int'(b);
      sa = a[W-1] ? ua - (1 << W) : ua;
      sb = b[W-1] ? ub - (1 << W) : ub;
      r  = sa - sb;
      d  = W'(ua - ub);
      bo = (ua < ub);
      ov = (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
   endtask

   task automatic chk_held(input string tag);
      chk({tag, "_diff"},   diff,     held_diff);
      chk({tag, "_borrow"}, borrow,   held_borrow);
      chk({tag, "_ovf"},    overflow, held_ovf);
   endtask

   // One operation from IDLE or FINISH. Optional fixed stall window, random stalls,
   // and disturbance of A/B/Start while running.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall_at, input int stall_len,
                        input bit rnd_en, input bit disturb);
      logic [W-1:0] e_d;
      logic         e_bo, e_ov;
      int cycles, processed, stalls;
      bit en_now;
      model(a, b, e_d, e_bo, e_ov);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      en    = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_accept", busy, 1);
      chk("done_accept", done, 0);
      cycles = 0;
      processed = 0;
      stalls = 0;
      while (processed < W && cycles < 64) begin
         en_now = !((cycles >= stall_at && cycles < stall_at + stall_len) ||
                    (rnd_en && $urandom_range(0, 3) == 0));
         en = en_now;
         if (disturb) begin
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         tick();
         cycles++;
         if (en_now) processed++;
         else        stalls++;
         if (processed < W) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk_held("hold_run");
         end
      end
      chk("latency", cycles, W + stalls);
      chk("done_pulse", done, 1);
      chk("busy_finish", busy, 0);
      chk("diff", diff, e_d);
      chk("borrow", borrow, e_bo);
      chk("ovf", overflow, e_ov);
      held_diff   = e_d;
      held_borrow = e_bo;
      held_ovf    = e_ov;
      start = 1'b0;
      en    = 1'b1;
   endtask

   task automatic idle_gap();
      start = 1'b0;
      en    = 1'($urandom_range(0, 1));
      tick();
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
      chk_held("hold_idle");
      en = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      #2;
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      tick();
      rst_n = 1'b1;
      en    = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      do_op(4'd5, 4'd3, 99, 0, 1'b0, 1'b0);
      idle_gap();
      do_op(4'd3, 4'd5, 99, 0, 1'b0, 1'b0);
      idle_gap();
      do_op(4'h8, 4'd1, 99, 0, 1'b0, 1'b0);
      idle_gap();
      do_op(4'd7, 4'h8, 99, 0, 1'b0, 1'b0);
      idle_gap();
      do_op(4'd9, 4'd9, 1, 3, 1'b0, 1'b1);
      // Back-to-back: Start taken straight from FINISH.
      do_op(4'd1, 4'd2, 99, 0, 1'b0, 1'b0);
      idle_gap();

      // Reset mid-run with two bits processed.
      a_in  = 4'd6;
      b_in  = 4'd2;
      start = 1'b1;
      en    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_diff", diff, 0);
      chk("midrst_borrow", borrow, 0);
      chk("midrst_ovf", overflow, 0);
      held_diff   = '0;
      held_borrow = 1'b0;
      held_ovf    = 1'b0;
      tick();
      chk("midrst_done2", done, 0);
      rst_n = 1'b1;
      idle_gap();
      do_op(4'd12, 4'd5, 99, 0, 1'b0, 1'b0);
      idle_gap();

      for (int i = 0; i < 40; i++) begin
         do_op(W'($urandom), W'($urandom), 99, 0, 1'b1, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_gap();
      end
      idle_gap();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
